// File: rtl/priority_encoder_queue.sv
// priority_encoder_queue: sticky request capture issued one index per cycle through a valid/ready register
module priority_encoder_queue #(
  parameter int N = 8,
  parameter int MODE = 0,
  localparam int W = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         clr,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending
);
  logic [W-1:0] ptr;
  logic [W-1:0] sel;
  logic [W-1:0] j;
  logic         found;
  logic         load;
  logic         hit;
  logic [N-1:0] clear_mask;
  int           base;
  assign load = !out_valid || out_ready;
  assign hit = load && (|pending);
  assign clear_mask = hit ? (N'(1) << sel) : '0;
  // first pending bit scanning upward from the priority base, wrapping at N
  always_comb begin
    sel = '0;
    j = '0;
    found = 1'b0;
    base = (MODE != 0) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      j = W'((base + k) % N);
      if (!found && pending[j]) begin
        sel = j;
        found = 1'b1;
      end
    end
  end
  // request capture (set wins over issue-clear) and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      out_valid <= 1'b0;
      out_idx <= '0;
      ptr <= '0;
    end else if (clr) begin
      pending <= '0;
      out_valid <= 1'b0;
      ptr <= '0;
    end else begin
      pending <= (pending & ~clear_mask) | req;
      if (load) out_valid <= hit;
      if (hit) begin
        out_idx <= sel;
        if (MODE != 0) ptr <= (sel == W'(N - 1)) ? '0 : sel + 1'b1;
      end
    end
  end
endmodule

// File: doc/priority_encoder_queue.md
# priority_encoder_queue

Parametrised N-input priority encoder with sticky request capture and a registered valid/ready output. It is the sequential successor of the 4-to-2 encoder. Single-cycle request pulses are latched, then emitted one index at a time to a downstream consumer, so no request is lost under backpressure. Priority is fixed (lowest index wins) or round-robin, chosen by parameter.

## Interface
- N, default 8: number of request lines; legal N >= 2; need not be a power of 2.
- MODE, default 0: 0 = fixed priority (index 0 highest); 1 = round-robin.
- W (localparam) = max(1, clog2(N)): index width.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request lines; bit i high in a cycle sets pending[i].
- clr  input  1  synchronous flush of all pending and output state.
- out_idx  output  W  encoded index of the granted request.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  consumer accepts out_idx when out_valid && out_ready.
- pending  output  N  latched, not-yet-issued requests; registered.

## Operation
- Reset (rst_n low, asynchronous): pending = 0, out_valid = 0, out_idx = 0, RR pointer ptr = 0. All outputs are held at these values until the first clk edge after rst_n rises.
- The load condition is `load = !out_valid || out_ready`, evaluated every cycle.
- Selection in fixed mode: sel = lowest set bit of pending.
- Selection in round-robin mode: sel = first set bit of pending found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- When load is high and pending != 0:
  - out_idx <= sel and out_valid <= 1.
  - pending[sel] is cleared.
  - In RR mode, ptr <= (sel == N-1) ? 0 : sel+1.
- When load is high and pending == 0: out_valid <= 0; out_idx holds its last value; ptr is unchanged.
- When load is low (stall): out_idx, out_valid and ptr all hold.
- Pending update each cycle: pending <= (pending & ~clear_mask) | req.
  - clear_mask is the one-hot sel when a load occurs, else 0.
  - Set wins: if req[sel] is high in the cycle sel is issued, the bit stays pending.
- A request already pending is not counted twice; repeated pulses on a pending bit merge.
- clr high: pending <= 0, out_valid <= 0, ptr <= 0. req in the same cycle is discarded. clr overrides load and set.
- Only one index is issued per cycle. Throughput is 1 per cycle with out_ready held high.

## Timing
- Latency: req[i] high at edge k puts pending[i] = 1 after edge k. With the output stage free, out_valid = 1 and out_idx = i after edge k+1 (2 cycles request-to-valid).
- out_idx and out_valid are stable while out_valid && !out_ready. The consumer may sample them at any stalled cycle.
- The transfer completes on the edge where out_valid && out_ready. The next index (if any) appears on that same edge, with no bubble.
- Round-robin guarantee: with all N bits continuously requested, every index is issued exactly once in any N consecutive transfers.
- Fixed-mode starvation of high indices is permitted by design.
- Wrap: ptr after issuing N-1 is 0. For a non-power-of-2 N, out_idx never exceeds N-1.
- Asynchronous reset asserted mid-transfer drops all pending and in-flight indices immediately; no partial output.
- Deasserting out_ready while out_valid is low has no effect.

## Test plan
- Fixed mode, N=8, out_ready=1: pulse req=8'b1010_0100 for one cycle -> out_idx sequence 2, 5, 7 on consecutive cycles starting 2 cycles after the pulse; then out_valid=0 and pending=0.
- Backpressure, fixed mode: req=8'b0000_0011 pulse, out_ready=0 for 5 cycles -> out_idx=0 held with out_valid=1 and pending=8'b0000_0010 throughout. Raise out_ready -> out_idx 0 then 1, then out_valid=0.
- Round-robin, N=4, req=4'b1111 held, out_ready=1 -> out_idx 0, 1, 2, 3, 0, 1, ... Then drop req[1] -> index 1 is skipped once pending[1] is issued.
- Set-wins collision: pending[3]=1 being issued while req[3]=1 in the same cycle -> pending[3] remains 1, and index 3 is issued again later.
- clr: pending=8'hF0, out_valid=1, clr=1 with req=8'h01 in the same cycle -> next cycle pending=0, out_valid=0, and index 0 is never issued.
- Reset mid-operation: pending nonzero, out_valid=1, pull rst_n low between edges -> outputs go to 0 immediately without a clock. After release with req=0 -> out_valid stays 0.
